// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants and state encoding for the instruction-fetch
//             stage (fetch_unit and its IF/ID register).
//  Contents : NOP_INSTR       - canonical bubble instruction (addi x0,x0,0)
//             fetch_state_t   - FETCH / HOLD state encoding
//             PC_STEP_DEFAULT - default sequential PC increment in bytes
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int PC_STEP_DEFAULT = 4;

    typedef logic [0:0] fetch_state_t;

    // FETCH: request line driven, waiting for (or streaming) acks.
    // HOLD : a fetched word is parked in the hold buffer behind a stall.
    localparam fetch_state_t FETCH = 1'b0;
    localparam fetch_state_t HOLD  = 1'b1;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register holding pc/instr/valid for decode.
//             Control priority: flush > hold > load > bubble.
//             Flush and bubble both give valid=0, instr=NOP and keep pc.
//  Ports    : clk_i, rst_n_i      - clock, async active-low reset
//             flush_i             - squash contents (branch redirect)
//             hold_i              - freeze contents (load-use stall)
//             load_i              - capture pc_d_i / instr_d_i as valid
//             pc_d_i, instr_d_i   - incoming PC and instruction
//             pc_o, instr_o, valid_o - registered outputs to decode
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_d_i,
    input  logic [31:0]     instr_d_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (hold_i) begin
            r_pc    <= r_pc;
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else if (load_i) begin
            r_pc    <= pc_d_i;
            r_instr <= instr_d_i;
            r_valid <= 1'b1;
        end else begin
            // Nothing to hand over: insert a bubble, pc_o left as it was.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign pc_o    = r_pc;
    assign instr_o = r_instr;
    assign valid_o = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage with IF/ID register. Owns the fetch PC,
//             drives a req/ack instruction memory port, parks a word in a
//             hold buffer when decode stalls, and redirects on branches.
//  Ports    : clk_i, rst_n_i                 - clock, async active-low reset
//             imem_req_o, imem_addr_o        - fetch request / address
//             imem_ack_i, imem_data_i        - memory response
//             stall_i                        - load-use stall from hazard unit
//             branch_taken_i, branch_target_i - redirect from EX
//             pc_o, instr_o, valid_o         - IF/ID outputs to decode
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(PC_STEP);

    fetch_state_t    r_state;
    logic            r_req;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_squash;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_hold_pc;
    logic [31:0]     r_hold_instr;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic            w_squash_nxt;
    logic [XLEN-1:0] w_target_nxt;
    logic            w_hold_load;
    logic            w_ack;
    logic            w_outstanding;
    logic            w_ifid_load;
    logic [XLEN-1:0] w_ifid_pc;
    logic [31:0]     w_ifid_instr;

    // r_req is only high in FETCH, so an ack is meaningful only when it is.
    assign w_ack         = r_req & imem_ack_i;
    assign w_outstanding = r_req & ~imem_ack_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_squash_nxt   = r_squash;
        w_target_nxt   = r_target;
        w_hold_load    = 1'b0;
        if (branch_taken_i) begin
            w_state_nxt = FETCH;
            if (w_outstanding) begin
                // Address must stay stable until the memory answers, so the
                // redirect is deferred; a newer branch overwrites the target.
                w_squash_nxt = 1'b1;
                w_target_nxt = branch_target_i;
            end else begin
                w_squash_nxt   = 1'b0;
                w_fetch_pc_nxt = branch_target_i;
            end
        end else if (r_state == HOLD) begin
            if (!stall_i) begin
                w_state_nxt = FETCH;
            end
        end else if (w_ack) begin
            if (r_squash) begin
                w_squash_nxt   = 1'b0;
                w_fetch_pc_nxt = r_target;
            end else begin
                w_fetch_pc_nxt = r_fetch_pc + C_PC_STEP;
                if (stall_i) begin
                    w_state_nxt = HOLD;
                    w_hold_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= FETCH;
            r_req        <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_squash     <= 1'b0;
            r_target     <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= (w_state_nxt == FETCH);
            r_fetch_pc <= w_fetch_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_target   <= w_target_nxt;
            if (w_hold_load) begin
                r_hold_pc    <= r_fetch_pc;
                r_hold_instr <= imem_data_i;
            end
        end
    end

    // In HOLD the buffered word is handed over; otherwise a fresh, unsquashed
    // ack goes straight to decode. Stall (hold) and branch (flush) take
    // precedence inside the register.
    assign w_ifid_load  = (r_state == HOLD) | (w_ack & ~r_squash);
    assign w_ifid_pc    = (r_state == HOLD) ? r_hold_pc    : r_fetch_pc;
    assign w_ifid_instr = (r_state == HOLD) ? r_hold_instr : imem_data_i;

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (branch_taken_i),
        .hold_i    (stall_i),
        .load_i    (w_ifid_load),
        .pc_d_i    (w_ifid_pc),
        .instr_d_i (w_ifid_instr),
        .pc_o      (pc_o),
        .instr_o   (instr_o),
        .valid_o   (valid_o)
    );

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_fetch_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. Memory returns
//             32'h1000_0000 + address as the instruction word. Expected
//             fetch addresses and IF/ID outputs are queued as stimulus is
//             issued; a negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q_addr[$];
    ifid_t       q_ifid[$];
    logic        prev_stall = 1'b0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .valid_o         (valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Stall seen at the last edge: when set, IF/ID merely held its contents.
    always @(posedge clk_i) prev_stall <= stall_i;

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (imem_ack_i) begin
                n_vec += 1;
                if (q_addr.size() == 0) begin
                    n_bad += 1;
                    $display("FAIL fetch_addr: unexpected ack, got req=%0b addr=%h, expected none", imem_req_o, imem_addr_o);
                end else begin
                    logic [31:0] ea;
                    ea = q_addr.pop_front();
                    if (!imem_req_o || imem_addr_o !== ea) begin
                        n_bad += 1;
                        $display("FAIL fetch_addr: got req=%0b addr=%h, expected req=1 addr=%h", imem_req_o, imem_addr_o, ea);
                    end
                end
            end
            if (!prev_stall && valid_o) begin
                n_vec += 1;
                if (q_ifid.size() == 0) begin
                    n_bad += 1;
                    $display("FAIL ifid_out: unexpected valid pc=%h instr=%h, expected none", pc_o, instr_o);
                end else begin
                    ifid_t ei;
                    ei = q_ifid.pop_front();
                    if (pc_o !== ei.pc || instr_o !== ei.instr) begin
                        n_bad += 1;
                        $display("FAIL ifid_out: got pc=%h instr=%h, expected pc=%h instr=%h", pc_o, instr_o, ei.pc, ei.instr);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec += 1;
        if (act !== exp) begin
            n_bad += 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        q_addr.push_back(a);
    endtask

    task automatic exp_out(input logic [31:0] pc);
        q_ifid.push_back({pc, 32'h1000_0000 + pc});
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic drive(input logic ack, input logic stall, input logic br, input logic [31:0] tgt);
        imem_ack_i      = ack;
        imem_data_i     = ack ? 32'h1000_0000 + imem_addr_o : 32'hDEAD_BEEF;
        stall_i         = stall;
        branch_taken_i  = br;
        branch_target_i = tgt;
        @(posedge clk_i);
        #1;
        imem_ack_i     = 1'b0;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b1;
        #1 rst_n_i = 1'b0;
        #2;
        chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc",    pc_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        drive(0, 0, 0, 0);
        chk("first_req",  {31'd0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);

        // Zero-wait streaming
        exp_fetch(32'h0); exp_out(32'h0); drive(1, 0, 0, 0);
        exp_fetch(32'h4); exp_out(32'h4); drive(1, 0, 0, 0);

        // Three wait cycles at 0x8
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            chk("wait_addr",  imem_addr_o, 32'h8);
            chk("wait_valid", {31'd0, valid_o}, 32'd0);
            chk("wait_instr", instr_o, NOP);
            chk("wait_pc",    pc_o, 32'h4);
        end
        exp_fetch(32'h8); exp_out(32'h8); drive(1, 0, 0, 0);
        exp_fetch(32'hC); exp_out(32'hC); drive(1, 0, 0, 0);

        // Stall while ack returns for 0x10
        exp_fetch(32'h10); exp_out(32'h10); drive(1, 1, 0, 0);
        chk("hold_req", {31'd0, imem_req_o}, 32'd0);
        chk("hold_pc",  pc_o, 32'hC);
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        drive(0, 1, 0, 0);
        chk("hold2_req", {31'd0, imem_req_o}, 32'd0);
        chk("hold2_pc",  pc_o, 32'hC);
        drive(0, 0, 0, 0);
        chk("release_req",  {31'd0, imem_req_o}, 32'd1);
        chk("release_addr", imem_addr_o, 32'h14);
        chk("release_pc",   pc_o, 32'h10);
        exp_fetch(32'h14); exp_out(32'h14); drive(1, 0, 0, 0);
        exp_fetch(32'h18); exp_out(32'h18); drive(1, 0, 0, 0);
        exp_fetch(32'h1C); exp_out(32'h1C); drive(1, 0, 0, 0);

        // Branch while 0x20 outstanding
        drive(0, 0, 1, 32'h100);
        chk("br_valid", {31'd0, valid_o}, 32'd0);
        chk("br_instr", instr_o, NOP);
        chk("br_addr",  imem_addr_o, 32'h20);
        chk("br_req",   {31'd0, imem_req_o}, 32'd1);
        drive(0, 0, 0, 0);
        chk("squash_addr", imem_addr_o, 32'h20);
        exp_fetch(32'h20); drive(1, 0, 0, 0);
        chk("squash_valid", {31'd0, valid_o}, 32'd0);
        chk("redir_addr",   imem_addr_o, 32'h100);
        exp_fetch(32'h100); exp_out(32'h100); drive(1, 0, 0, 0);

        // Branch and stall together, with ack: flush wins
        exp_fetch(32'h104); drive(1, 1, 1, 32'h200);
        chk("brst_valid", {31'd0, valid_o}, 32'd0);
        chk("brst_instr", instr_o, NOP);
        chk("brst_addr",  imem_addr_o, 32'h200);
        chk("brst_req",   {31'd0, imem_req_o}, 32'd1);

        // Two redirects before ack: newest target wins
        drive(0, 0, 1, 32'h300);
        drive(0, 0, 1, 32'h400);
        chk("dbl_addr", imem_addr_o, 32'h200);
        exp_fetch(32'h200); drive(1, 0, 0, 0);
        chk("dbl_redir", imem_addr_o, 32'h400);
        exp_fetch(32'h400); exp_out(32'h400); drive(1, 0, 0, 0);

        // Branch while in HOLD drops the buffered word
        exp_fetch(32'h404); drive(1, 1, 0, 0);
        chk("hbr_hold_req", {31'd0, imem_req_o}, 32'd0);
        drive(0, 1, 1, 32'h500);
        chk("hbr_req",   {31'd0, imem_req_o}, 32'd1);
        chk("hbr_addr",  imem_addr_o, 32'h500);
        chk("hbr_valid", {31'd0, valid_o}, 32'd0);
        exp_fetch(32'h500); exp_out(32'h500); drive(1, 0, 0, 0);

        // PC wrap at top of address space
        drive(0, 0, 1, 32'hFFFF_FFFC);
        exp_fetch(32'h504); drive(1, 0, 0, 0);
        chk("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
        exp_fetch(32'hFFFF_FFFC); exp_out(32'hFFFF_FFFC); drive(1, 0, 0, 0);
        chk("wrap_addr", imem_addr_o, 32'h0);
        exp_fetch(32'h0); exp_out(32'h0); drive(1, 0, 0, 0);

        // Reset while waiting at 0x40 with a valid word held in IF/ID
        drive(0, 0, 1, 32'h3C);
        exp_fetch(32'h4); drive(1, 0, 0, 0);
        chk("pre_rst_addr", imem_addr_o, 32'h3C);
        exp_fetch(32'h3C); exp_out(32'h3C); drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("pre_rst_wait",  imem_addr_o, 32'h40);
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        rst_n_i = 1'b0;
        #2;
        chk("arst_req",   {31'd0, imem_req_o}, 32'd0);
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_instr", instr_o, NOP);
        chk("arst_addr",  imem_addr_o, 32'h0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        drive(0, 0, 0, 0);
        chk("post_rst_req",  {31'd0, imem_req_o}, 32'd1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        exp_fetch(32'h0); exp_out(32'h0); drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        chk("addr_queue_left", q_addr.size(), 32'd0);
        chk("ifid_queue_left", q_ifid.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode stage, which in turn drives the ID/EX buffer.
- Owns the fetch PC and drives a req/ack instruction-memory port.
- Presents pc/instr/valid to decode.
- Honours load-use stall from the hazard unit and branch-taken redirect/flush from EX.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk_i  input  1  clock, all state on posedge
rst_n_i  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request, held until ack
imem_addr_o  output  XLEN  fetch address, stable while req high and not acked
imem_ack_i  input  1  memory returns imem_data_i this cycle (req high required)
imem_data_i  input  32  instruction word, valid with ack
stall_i  input  1  hazard unit: hold IF/ID contents
branch_taken_i  input  1  EX: redirect fetch, flush IF/ID
branch_target_i  input  XLEN  redirect address, valid with branch_taken_i
pc_o  output  XLEN  IF/ID: PC of instr_o
instr_o  output  32  IF/ID: instruction to decode
valid_o  output  1  IF/ID: instr_o is real (not bubble)

Behaviour:
- Reset is asynchronous and active-low. Clock is clk_i, reset is rst_n_i.
- Reset values (async, immediate on rst_n_i low):
  - fetch_pc=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0.
  - pc_o=0, instr_o=NOP (32'h0000_0013), valid_o=0.
  - state=FETCH, squash=0, hold buffer empty.
- First posedge after release: imem_req_o=1. imem_addr_o always equals fetch_pc.
- State FETCH (imem_req_o=1):
  - No ack: hold address. IF/ID holds if stall_i, else loads bubble (valid_o=0, instr_o=NOP, pc_o unchanged).
  - Ack, squash=0, no branch, stall_i=0: pc_o<=fetch_pc, instr_o<=imem_data_i, valid_o<=1, fetch_pc<=fetch_pc+PC_STEP. req stays high, so zero-wait memory sustains 1 instr/cycle.
  - Ack, squash=0, no branch, stall_i=1: word+PC go to hold buffer; fetch_pc+=PC_STEP; state<=HOLD; IF/ID unchanged.
  - Ack with squash=1: data discarded; squash<=0; fetch_pc<=stored redirect target; IF/ID per stall/bubble rule.
- State HOLD (imem_req_o=0):
  - IF/ID unchanged while stall_i=1.
  - First edge with stall_i=0: buffer moves to IF/ID, valid_o<=1, state<=FETCH.
- branch_taken_i (priority over stall_i and ack):
  - IF/ID flushed that edge: valid_o<=0, instr_o<=NOP.
  - Hold buffer dropped; state<=FETCH.
  - If a request is outstanding and unacked: squash<=1, target saved, address stays stable until ack.
  - Else (acked this edge, or in HOLD): fetch_pc<=branch_target_i directly, data discarded.
- Branch during squash (second redirect before ack): saved target overwritten with the newest; squash stays 1.
- Arithmetic: PC add is modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0, no flag.
- Reset mid-request: outstanding request abandoned; the memory must tolerate a dropped request.

Decomposition:
- Package fetch_pkg: NOP_INSTR constant, fetch_state_t {FETCH, HOLD}, PC_STEP default.
- One sub-module, if_id_reg: pc/instr/valid register with load, hold (stall) and flush (NOP, valid=0) controls.
- FSM, squash logic and hold buffer stay in fetch_unit.

Test Plan:
- Zero-wait ack every cycle, no stall, RESET_PC=0 -> addresses 0,4,8,C on consecutive cycles; pc_o/instr_o follow one cycle later; valid_o=1 continuous.
- Ack after 3 wait cycles at addr 8 -> imem_addr_o stays 8 all 4 cycles; valid_o=0 (NOP) for 3 cycles, then pc_o=8.
- stall_i high 2 cycles while ack returns for addr 0x10 -> IF/ID frozen; imem_req_o=0 in HOLD; on release pc_o=0x10, next request addr 0x14.
- branch_taken_i, target 0x100, while addr 0x20 is unacked (ack 2 cycles later) -> valid_o=0 immediately; 0x20 data never appears on instr_o; next request addr 0x100.
- branch_taken_i and stall_i in the same cycle -> flush wins: valid_o=0, instr_o=32'h13, fetch from target.
- Assert rst_n_i mid-wait at addr 0x40 -> imem_req_o=0 and valid_o=0 asynchronously; after release first fetch is RESET_PC.
